// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
// Shared types and the byte-sequence table for i2c_reg_sequencer.
//   state_t      : sequencer states
//   err_t        : response status codes (0 OK, 1 NACK, 2 ARB, 3 TIMEOUT)
//   byte_entry_t : one presented byte {data, mode, cont, start}
//   seq_entry()  : returns byte entry idx of a register read or write
//   last_index() : index of the final byte of a read or write
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    XFER,
    DRAIN,
    STOP_WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_ARB     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  typedef struct packed {
    logic [7:0] data;
    logic       mode;
    logic       cont;
    logic       start;
  } byte_entry_t;

  // Read byte that lets the master finish cleanly after an address NACK
  localparam byte_entry_t DRAIN_ENTRY = '{data: 8'hFF, mode: 1'b1, cont: 1'b0, start: 1'b0};

  // Quiet presentation: no start, no continue, so the master issues STOP
  localparam byte_entry_t IDLE_ENTRY  = '{data: 8'hFF, mode: 1'b0, cont: 1'b0, start: 1'b0};

  function automatic logic [2:0] last_index(input logic rd);
    return rd ? 3'd3 : 3'd2;
  endfunction

  // Indices past the end of a sequence yield IDLE_ENTRY, which is what the
  // master must see when the last byte completes.
  function automatic byte_entry_t seq_entry(input logic       rd,
                                            input logic [6:0] dev,
                                            input logic [7:0] reg_addr,
                                            input logic [7:0] wdata,
                                            input logic [2:0] idx);
    byte_entry_t e;
    e = IDLE_ENTRY;
    if (rd) begin
      case (idx)
        3'd0:    e = '{data: {dev, 1'b0}, mode: 1'b0, cont: 1'b1, start: 1'b1};
        3'd1:    e = '{data: reg_addr,    mode: 1'b0, cont: 1'b0, start: 1'b0};
        3'd2:    e = '{data: {dev, 1'b1}, mode: 1'b0, cont: 1'b1, start: 1'b1};
        3'd3:    e = '{data: 8'hFF,       mode: 1'b1, cont: 1'b0, start: 1'b0};
        default: e = IDLE_ENTRY;
      endcase
    end else begin
      case (idx)
        3'd0:    e = '{data: {dev, 1'b0}, mode: 1'b0, cont: 1'b1, start: 1'b1};
        3'd1:    e = '{data: reg_addr,    mode: 1'b0, cont: 1'b1, start: 1'b0};
        3'd2:    e = '{data: wdata,       mode: 1'b0, cont: 1'b0, start: 1'b0};
        default: e = IDLE_ENTRY;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Expands one register read/write request into the byte-level handshake of
// i2c_master and returns a single-cycle response with read data and status.
// Ports:
//   clk_in, reset (sync, active-high)
//   req_valid/req_ready, req_read, req_dev_addr[6:0], req_reg_addr, req_wdata
//   resp_valid, resp_rdata, resp_err[1:0]
//   m_mode, m_transfer_start, m_transfer_continue, m_data_tx  -> master
//   m_transfer_ready, m_transaction_complete, m_nack,
//   m_start_err, m_arbitration_err, m_data_rx                 <- master
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic [1:0] resp_err,
  output logic       m_mode,
  output logic       m_transfer_start,
  output logic       m_transfer_continue,
  output logic [7:0] m_data_tx,
  input  logic       m_transfer_ready,
  input  logic       m_transaction_complete,
  input  logic       m_nack,
  input  logic       m_start_err,
  input  logic       m_arbitration_err,
  input  logic [7:0] m_data_rx
);

  localparam int             WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic [2:0]  idx, idx_d;
  err_t        err_q, err_d;
  logic [7:0]  cap_q, cap_d;
  logic        rd_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [WD_W-1:0] wd;
  logic        wd_clr;
  logic        active;
  logic        abort;
  logic        timeout;
  logic        is_last;
  byte_entry_t cur, nxt, pres;

  assign active  = (state == START) || (state == XFER) || (state == DRAIN) || (state == STOP_WAIT);
  assign abort   = active && (m_arbitration_err || m_start_err);
  assign timeout = active && (wd == WD_LIMIT);
  assign cur     = seq_entry(rd_q, dev_q, reg_q, wdata_q, idx);
  assign nxt     = seq_entry(rd_q, dev_q, reg_q, wdata_q, idx + 3'd1);
  assign is_last = (idx == last_index(rd_q));

  // Next-state logic and the byte presented to the master. On a complete the
  // following entry is shown immediately, because the master latches its
  // continuation byte on the edge after the complete pulse.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    err_d   = err_q;
    cap_d   = cap_q;
    wd_clr  = 1'b0;
    pres    = IDLE_ENTRY;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = START;
          idx_d   = 3'd0;
          err_d   = ERR_OK;
          cap_d   = 8'h00;
          wd_clr  = 1'b1;
        end
      end
      START: begin
        pres = m_transaction_complete ? nxt : cur;
        if (m_transfer_ready) state_d = XFER;
      end
      XFER: begin
        pres = cur;
        if (m_transaction_complete) begin
          wd_clr = 1'b1;
          // A NACK on the final read byte is the intended end of the read
          if (m_nack && !(rd_q && is_last)) begin
            if (err_q == ERR_OK) err_d = ERR_NACK;
            if (cur.cont) begin
              pres    = DRAIN_ENTRY;
              state_d = DRAIN;
            end else begin
              pres    = IDLE_ENTRY;
              state_d = STOP_WAIT;
            end
          end else if (is_last) begin
            pres    = IDLE_ENTRY;
            if (rd_q) cap_d = m_data_rx;
            state_d = STOP_WAIT;
          end else begin
            pres  = nxt;
            idx_d = idx + 3'd1;
          end
        end
      end
      DRAIN: begin
        pres = DRAIN_ENTRY;
        if (m_transaction_complete) begin
          wd_clr  = 1'b1;
          pres    = IDLE_ENTRY;
          state_d = STOP_WAIT;
        end
      end
      STOP_WAIT: begin
        if (m_transfer_ready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus loss outranks a watchdog expiry, which outranks a NACK; only the
    // first recorded error of a transaction is reported.
    if (abort) begin
      if (err_q == ERR_OK) err_d = ERR_ARB;
      pres    = IDLE_ENTRY;
      state_d = STOP_WAIT;
    end else if (timeout) begin
      if (err_q == ERR_OK) err_d = ERR_TIMEOUT;
      pres    = IDLE_ENTRY;
      state_d = RESP;
    end
  end

  // State, request latch, watchdog and response registers. The response is
  // loaded only when RESP is entered so resp_rdata holds between responses.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      err_q      <= ERR_OK;
      cap_q      <= 8'h00;
      rd_q       <= 1'b0;
      dev_q      <= 7'h00;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      wd         <= '0;
      resp_rdata <= 8'h00;
      resp_err   <= 2'd0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      err_q <= err_d;
      cap_q <= cap_d;
      if (state == IDLE && req_valid) begin
        rd_q    <= req_read;
        dev_q   <= req_dev_addr;
        reg_q   <= req_reg_addr;
        wdata_q <= req_wdata;
      end
      if (wd_clr) begin
        wd <= '0;
      end else if (active && wd != {WD_W{1'b1}}) begin
        wd <= wd + 1'b1;
      end
      if (state_d == RESP && state != RESP) begin
        resp_err   <= err_d;
        resp_rdata <= (err_d == ERR_OK) ? cap_d : 8'h00;
      end
    end
  end

  assign req_ready           = (state == IDLE);
  assign resp_valid          = (state == RESP);
  assign m_data_tx           = pres.data;
  assign m_mode              = pres.mode;
  assign m_transfer_continue = pres.cont;
  assign m_transfer_start    = pres.start;

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Register-access front end that sits directly upstream of `i2c_master` and drives its byte-level transfer handshake. It accepts one register read or write request and expands it into the correct I2C byte sequence. A write is START, address+W, register, data, STOP. A read is START, address+W, register, repeated START, address+R, one data byte received with NACK, STOP. It reports the read data and a status code on a single-cycle response, and it converts master NACK, arbitration and start errors and watchdog expiry into clean status codes.

## Interface
- `TIMEOUT_CYCLES`, 1000000: watchdog limit, in `clk_in` cycles, without master progress; must be ≥ 2.
- `clk_in`  in  1  clock; the same clock as `i2c_master.clk_in`.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request strobe; sampled only while `req_ready`=1.
- `req_ready`  out  1  high only in IDLE.
- `req_read`  in  1  1 = register read, 0 = register write.
- `req_dev_addr`  in  7  7-bit device address.
- `req_reg_addr`  in  8  register pointer.
- `req_wdata`  in  8  write data.
- `resp_valid`  out  1  one-cycle pulse on completion.
- `resp_rdata`  out  8  read byte; held until the next `resp_valid`; 0 for writes and errors.
- `resp_err`  out  2  0 = OK, 1 = NACK, 2 = ARB (arbitration or start error), 3 = TIMEOUT.
- `m_mode`, `m_transfer_start`, `m_transfer_continue`  out  1 each  to the master.
- `m_data_tx`  out  8  to the master.
- `m_transfer_ready`, `m_transaction_complete`, `m_nack`, `m_start_err`, `m_arbitration_err`  in  1 each  from the master.
- `m_data_rx`  in  8  from the master.

## Operation
- Reset values:
  - state = IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `m_transfer_start`=0, `m_transfer_continue`=0, `m_mode`=0, `m_data_tx`=8'hFF.
- On acceptance (`req_valid`&&`req_ready`), latch all request fields, set byte index `idx`=0, and enter START.
- Byte sequence, as {data, mode, continue, start}:
  - Write: B0 {dev,0}/0/1/1, B1 reg/0/1/0, B2 wdata/0/0/0.
  - Read: B0 {dev,0}/0/1/1, B1 reg/0/0/0, B2 {dev,1}/0/1/1, B3 8'hFF/1/0/0.
- Presented `m_*` outputs are combinational:
  - When `m_transaction_complete`=1, present entry `idx+1`.
  - Otherwise present entry `idx`.
  - Reason: the master latches the continuation byte on the edge that follows its complete pulse.
- States:
  - IDLE: `m_transfer_start`=0.
  - START: present B0. The edge with `m_transfer_ready`=1 is treated as acceptance → XFER.
  - XFER: each sampled complete increments `idx`. Stay in XFER until the last byte of the sequence completes, then → STOP_WAIT.
  - STOP_WAIT: present start=0, continue=0, mode=0, data 8'hFF. The edge with `m_transfer_ready`=1 → RESP.
  - RESP: `resp_valid`=1 for one cycle → IDLE.
- Read data: `m_data_rx` is captured into `resp_rdata` on the complete of B3.
- NACK (`m_nack`=1 on a complete for a transmit byte, B0–B2):
  - Set the error to NACK.
  - If that byte had continue=1, present the drain byte {8'hFF, mode 1, continue 0, start 0} in the same cycle and → DRAIN. DRAIN's own complete → STOP_WAIT.
  - Otherwise → STOP_WAIT directly.
  - A NACK on B3 is normal and is not an error.
- `m_arbitration_err` or `m_start_err` seen in any state other than IDLE/RESP:
  - Set the error to ARB and → STOP_WAIT; the master has already released the bus.
  - `resp_rdata` = 0.
- Watchdog:
  - Counter `wd` is cleared on entry to START and on every sampled complete, and increments in START/XFER/DRAIN/STOP_WAIT.
  - When `wd`==`TIMEOUT_CYCLES-1`, error = TIMEOUT and → RESP immediately; the STOP is not awaited.
- Error precedence in one cycle: ARB > TIMEOUT > NACK. The first recorded error is kept.
- Reset asserted mid-transfer: return to reset values next edge. No STOP is generated; the bus is recovered by the master's own timeouts.

## Timing
- `req_ready` deasserts the cycle after acceptance.
- `resp_valid` asserts exactly 1 cycle after the STOP_WAIT exit edge.
- Watchdog counter width: `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.
- A request arriving in the same cycle as `resp_valid` is not accepted (`req_ready`=0 in RESP).
- `m_transfer_start` is never asserted while a segment's last byte is in flight, so the master always sees start=0 at its STOP decision unless a repeated START is intended.

## Structure
- Package `i2c_seq_pkg`:
  - state enum: IDLE, START, XFER, DRAIN, STOP_WAIT, RESP.
  - error codes: ERR_OK, ERR_NACK, ERR_ARB, ERR_TIMEOUT.
  - byte-entry struct {data, mode, cont, start}.
  - constant `DRAIN_ENTRY`.
- No sub-module. The byte table is a pure function in the package; the state machine, watchdog and response registers are local.

## Test plan
1. Write dev 0x50, reg 0x10, data 0xA5 against the master plus an ACKing slave model:
   - bus carries 0xA0, 0x10, 0xA5, then STOP.
   - `resp_err`=0, `resp_valid` is one pulse.
2. Read dev 0x50, reg 0x22, slave returns 0x3C:
   - bus carries 0xA0, 0x22, repeated START, 0xA1, then 0x3C with NACK and STOP.
   - `resp_rdata`=0x3C, `resp_err`=0.
3. Write with no device present (address NACKed):
   - the drain byte is read, then STOP follows.
   - `resp_err`=1, `resp_rdata`=0.
4. Arbitration loss injected during B1 (`m_arbitration_err` pulse):
   - `resp_err`=2, back to IDLE, the next request succeeds.
5. `TIMEOUT_CYCLES`=64, slave holds SCL low after B0:
   - `resp_valid` arrives 64 cycles after the last progress event.
   - `resp_err`=3, `req_ready`=1 on the following cycle.
6. `reset` asserted during XFER of B2:
   - all outputs return to reset values on the next edge.
   - `req_ready`=1 and no `resp_valid` pulse.
